// File: rtl/e_mdu_if.sv
// E-stage multiply/divide bus: operands and op code from the execute stage,
// busy/start status to the hazard unit, and mfhi/mflo read data back to E_MRegister.
interface e_mdu_if;
  // Handshake: there is no valid/ready pair. An MD op is accepted on a rising edge
  // only when Req=0 and E_Busy=0. E_Start=1 marks the edge that launches mult/div.
  // While E_Busy=1 the producer must hold MD ops (1-8) off the bus.
  // E_MDData is combinational and is meaningful for mfhi/mflo only while E_Busy=0.
  logic        Req;
  logic [3:0]  E_MDOp;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        E_Start;
  logic        E_Busy;
  logic [31:0] E_MDData;

  modport master (
    output Req, E_MDOp, E_A, E_B,
    input  E_Start, E_Busy, E_MDData
  );

  modport slave (
    input  Req, E_MDOp, E_A, E_B,
    output E_Start, E_Busy, E_MDData
  );
endinterface

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Operands are latched at start; the result is written when the cycle counter expires.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  e_mdu_if.slave     md,
  output logic [0:0] dbg_state
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = ($clog2(MAX_CYCLES) < 1) ? 1 : $clog2(MAX_CYCLES);
  localparam logic [CW-1:0] MULT_LAST = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CYCLES - 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [3:0]    op_q, op_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic busy;
  logic is_calc;
  logic start;

  assign busy    = (state_q == ST_BUSY);
  assign is_calc = (md.E_MDOp >= OP_MULT) && (md.E_MDOp <= OP_DIVU);
  assign start   = is_calc && !md.Req && !busy;

  assign md.E_Start = start;
  assign md.E_Busy  = busy;
  assign dbg_state  = state_q;

  // Signed ops work on magnitudes and fix the sign afterwards, so one unsigned
  // multiplier and one unsigned divider serve both flavours. This also makes
  // 0x80000000 / -1 fall out naturally as 0x80000000 rem 0.
  logic        signed_op;
  logic        is_mul;
  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic [63:0] prod_mag, prod;
  logic [31:0] div_den;
  logic [31:0] quo_mag, rem_mag;
  logic [31:0] quo, rem;
  logic        div_zero;

  always_comb begin
    signed_op = (op_q == OP_MULT) || (op_q == OP_DIV);
    is_mul    = (op_q == OP_MULT) || (op_q == OP_MULTU);
    a_neg     = signed_op && a_q[31];
    b_neg     = signed_op && b_q[31];
    mag_a     = a_neg ? (32'd0 - a_q) : a_q;
    mag_b     = b_neg ? (32'd0 - b_q) : b_q;
    prod_mag  = {32'd0, mag_a} * {32'd0, mag_b};
    prod      = (a_neg ^ b_neg) ? (64'd0 - prod_mag) : prod_mag;
    div_zero  = (b_q == 32'd0);
    // Divider sees 1 instead of 0; the result is discarded in that case anyway.
    div_den   = div_zero ? 32'd1 : mag_b;
    quo_mag   = mag_a / div_den;
    rem_mag   = mag_a % div_den;
    quo       = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
    rem       = a_neg ? (32'd0 - rem_mag) : rem_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = md.E_A;
          b_d     = md.E_B;
          op_d    = md.E_MDOp;
          cnt_d   = ((md.E_MDOp == OP_MULT) || (md.E_MDOp == OP_MULTU)) ? MULT_LAST : DIV_LAST;
          state_d = ST_BUSY;
        end else if (!md.Req) begin
          if (md.E_MDOp == OP_MTHI) hi_d = md.E_A;
          if (md.E_MDOp == OP_MTLO) lo_d = md.E_A;
        end
      end
      ST_BUSY: begin
        // Req does not reach here: the in-flight op belongs to a committed instruction.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = ST_IDLE;
          if (is_mul) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (!div_zero) begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    md.E_MDData = 32'd0;
    case (md.E_MDOp)
      OP_MFHI: md.E_MDData = hi_q;
      OP_MFLO: md.E_MDData = lo_q;
      default: md.E_MDData = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Randomised and directed checks of e_mdu against an arithmetic HI/LO model,
// with mfhi/mflo results checked through an expected-value queue.
module tb_e_mdu;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [0:0] dbg_state;

  always #5 clk = ~clk;

  e_mdu_if bus ();

  e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .md        (bus),
    .dbg_state (dbg_state)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic        rd_en    = 1'b0;
  logic [31:0] hi_m     = 32'd0;
  logic [31:0] lo_m     = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural operands.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      4'd1: begin p = sa * sb; return p; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; return p; end
      4'd3: begin
        if (b == 32'd0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
      default: return {hi, lo};
    endcase
  endfunction

  // Monitor: whenever a read is presented, pop and compare.
  always @(negedge clk) begin
    if (rd_en) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 64'd1, 64'd0);
      end else begin
        check("md_data", {32'd0, bus.E_MDData}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  // Hazard rule: no MD op may be presented while busy.
  always @(negedge clk) begin
    if (!reset && bus.E_Busy) begin
      check("md_op_while_busy", {63'd0, (bus.E_MDOp >= 4'd1 && bus.E_MDOp <= 4'd8)}, 64'd0);
    end
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic req);
    @(posedge clk);
    #1;
    bus.E_MDOp = op;
    bus.E_A    = a;
    bus.E_B    = b;
    bus.Req    = req;
  endtask

  task automatic go_idle();
    bus.E_MDOp = 4'd0;
    bus.E_A    = $urandom;
    bus.E_B    = $urandom;
    bus.Req    = 1'b0;
  endtask

  task automatic rd(input logic [3:0] op);
    drive(op, $urandom, $urandom, 1'b0);
    rd_en = 1'b1;
    exp_q.push_back(op == 4'd5 ? hi_m : (op == 4'd6 ? lo_m : 32'd0));
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    go_idle();
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a, input logic req);
    drive(op, a, $urandom, req);
    @(negedge clk);
    check("mt_no_start", {63'd0, bus.E_Start}, 64'd0);
    if (!req) begin
      if (op == 4'd7) hi_m = a;
      else lo_m = a;
    end
    @(posedge clk);
    #1;
    go_idle();
  endtask

  // Launch a mult/div; optionally pulse Req during busy cycle req_at.
  task automatic do_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic req, input int req_at);
    int          cnt;
    int          n_exp;
    logic [63:0] res;
    n_exp = (op <= 4'd2) ? MULT_N : DIV_N;
    res   = model(op, a, b, hi_m, lo_m);
    drive(op, a, b, req);
    @(negedge clk);
    check("e_start", {63'd0, bus.E_Start}, {63'd0, !req});
    @(posedge clk);
    #1;
    go_idle();
    if (req) begin
      @(negedge clk);
      check("req_suppresses_busy", {63'd0, bus.E_Busy}, 64'd0);
    end else begin
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (!bus.E_Busy) break;
        cnt++;
        bus.Req = (cnt + 1 == req_at);
        bus.E_A = $urandom;
        bus.E_B = $urandom;
      end
      bus.Req = 1'b0;
      check("busy_cycles", 64'(cnt), 64'(n_exp));
      hi_m = res[63:32];
      lo_m = res[31:0];
    end
  endtask

  task automatic abort_test();
    drive(4'd3, 32'd100, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    go_idle();
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("abort_busy_before", {63'd0, bus.E_Busy}, 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy_after", {63'd0, bus.E_Busy}, 64'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;
    rd(4'd5);
    rd(4'd6);
  endtask

  logic [31:0] ra, rb;
  int          kind;

  initial begin
    bus.Req    = 1'b0;
    bus.E_MDOp = 4'd0;
    bus.E_A    = 32'd0;
    bus.E_B    = 32'd0;
    reset      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", {63'd0, bus.E_Busy}, 64'd0);
    check("reset_start", {63'd0, bus.E_Start}, 64'd0);
    rd(4'd5);
    rd(4'd6);

    do_calc(4'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, -1);
    rd(4'd5);
    rd(4'd6);
    do_calc(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, -1);
    rd(4'd5);
    rd(4'd6);
    do_calc(4'd4, 32'd7, 32'd2, 1'b0, -1);
    rd(4'd5);
    rd(4'd6);
    do_calc(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
    rd(4'd5);
    rd(4'd6);
    do_calc(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
    rd(4'd5);
    rd(4'd6);

    mt(4'd7, 32'h1234, 1'b0);
    do_calc(4'd1, 32'd3, 32'd4, 1'b1, -1);
    rd(4'd5);
    mt(4'd8, 32'hAB, 1'b0);
    do_calc(4'd3, 32'd9, 32'd0, 1'b0, -1);
    rd(4'd6);
    rd(4'd5);
    mt(4'd7, 32'hDEAD, 1'b1);
    rd(4'd5);
    do_calc(4'd1, 32'h7FFF_0001, 32'hFFFF_8000, 1'b0, 2);
    rd(4'd5);
    rd(4'd6);
    abort_test();

    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 4);
      ra   = $urandom;
      rb   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      case (kind)
        0, 1: do_calc(4'($urandom_range(1, 4)), ra, rb, ($urandom_range(0, 7) == 0), -1);
        2: mt(4'($urandom_range(7, 8)), ra, ($urandom_range(0, 5) == 0));
        3: rd(4'($urandom_range(5, 6)));
        default: rd(4'($urandom_range(9, 15)));
      endcase
    end
    rd(4'd5);
    rd(4'd6);
    rd(4'd0);
    rd(4'd12);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
